spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI initiator driving the 10-bit command/address/data frame protocol of the SPI slave + single-port RAM wrapper. Accepts one command word from a host-side request interface and serialises it on MOSI under SS_n. For read-data commands, captures the 8-bit RAM byte returned on MISO. Sits between the system host logic and the external SPI slave, sharing its clock.

## Interface
- `ADDR_SIZE`, 8: width of address/data payload; frame payload is `ADDR_SIZE+2` bits.
- `RD_LAT`, 2: cycles after the last MOSI bit before the first MISO bit is sampled.
- `GAP_CYC`, 2: minimum SS_n-high cycles between frames (≥1).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; accepted only when `ready`=1.
- `cmd`  in  2  command: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- `din`  in  ADDR_SIZE  address or write data; don't-care for rd-data.
- `ready`  out  1  idle, able to accept `start`.
- `done`  out  1  one-cycle pulse at frame completion.
- `rd_data`  out  ADDR_SIZE  last byte captured from MISO.
- `rd_valid`  out  1  one-cycle pulse with `done` on rd-data frames only.
- `SS_n`  out  1  slave select, active low.
- `MOSI`  out  1  serial data to slave, MSB first.
- `MISO`  in  1  serial data from slave.

## Operation
- States: IDLE, SEL, CMD, SHIFT, WAIT, CAPT, GAP.
- IDLE: `ready`=1, SS_n=1, MOSI=0. `start`=1 latches `cmd`/`din` into an (ADDR_SIZE+2)-bit shift register `{cmd,din}` → SEL.
- SEL (1 cycle): SS_n=0, MOSI=0 (slave leaves IDLE for CHK_CMD).
- CMD (1 cycle): MOSI=`cmd[1]` (0 = write path, 1 = read path).
- SHIFT (ADDR_SIZE+2 cycles): MOSI = shift-register MSB, shift left each cycle; bit counter counts down from ADDR_SIZE+1 to 0.
- After SHIFT: `cmd`=11 → WAIT; otherwise → GAP with `done`=1.
- WAIT (RD_LAT cycles): SS_n=0, MOSI=0.
- CAPT (ADDR_SIZE cycles): sample MISO each posedge into rx register, MSB first. On the last sample load `rd_data`, pulse `rd_valid` and `done` → GAP.
- GAP (GAP_CYC cycles): SS_n=1, MOSI=0 → IDLE.
- `start` while `ready`=0: ignored, no queueing.
- `rd_data` holds its value until the next rd-data frame completes.

## Timing
- All outputs registered. Reset values: SS_n=1, MOSI=0, `ready`=1, `done`=0, `rd_valid`=0, `rd_data`=0, state IDLE.
- `start` accepted at edge T, SS_n low from T+1.
- Write/rd-addr frame: SS_n low for 2+ADDR_SIZE+2 = 12 cycles. `done` is high in the first GAP cycle.
- Rd-data frame: SS_n low 12+RD_LAT+ADDR_SIZE = 22 cycles (defaults).
- `ready` returns GAP_CYC cycles after `done`. Back-to-back frame period is 12+GAP_CYC+1 cycles.
- `rst` mid-frame: next edge forces reset values; SS_n=1, frame aborted, no `done`/`rd_valid`, `rd_data` cleared.
- `start` coincident with `rst`: reset wins, request dropped.
- MISO is ignored outside CAPT.

## Structure
- Package `spi_pkg`: command encodings (`CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11) and state encodings (shared with the slave side).
- Sub-module `spi_master_shifter`: the TX parallel-load shift register, the RX shift register and the bit counter. The FSM lives in the top module.

## Test plan
- Reset 5 cycles, then check idle outputs → SS_n=1, MOSI=0, `ready`=1, `rd_data`=0.
- `start` with cmd=00, din=0x05 → MOSI sequence 0,0,00_00000101 under 12 low SS_n cycles; `done` once; the slave RAM latches address 5.
- cmd=01, din=0x07, then cmd=10, din=0x05, then cmd=11 → `rd_valid` with `rd_data`=0x07. Uses the slave+RAM wrapper as responder.
- Preload RAM[3]=0xA5; rd-addr 3 then rd-data → `rd_data`=0xA5 and `rd_valid` pulse is 1 cycle; check the 22-cycle SS_n window.
- Pulse `start` during SHIFT → ignored, frame bits unchanged, single `done`.
- Assert `rst` at the 6th SHIFT bit → SS_n=1 next cycle, no `done`; the following frame completes normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: command encodings, controller states and
// a small helper used to size counters from the timing parameters.
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_CMD,
      ST_SHIFT,
      ST_WAIT,
      ST_CAPT,
      ST_GAP
   } spiState_t;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath of the SPI initiator: parallel-load TX shift register, RX shift
// register and a reloadable down-counter that times every frame phase.
module spi_master_shifter
   import spi_pkg::*;
#(
   parameter int FRAME_W = 10,
   parameter int RX_W    = 8,
   parameter int CNT_W   = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_loadWord,
   input  logic               i_shiftTx,
   input  logic               i_shiftRx,
   input  logic               i_miso,
   input  logic               i_cntLoad,
   input  logic [CNT_W-1:0]   i_cntValue,
   input  logic               i_cntDec,
   output logic               o_txMsb,
   output logic [RX_W-1:0]    o_rxNext,
   output logic [CNT_W-1:0]   o_cnt
);

   logic [FRAME_W-1:0] r_tx;
   logic [RX_W-1:0]    r_rx;
   logic [CNT_W-1:0]   r_cnt;

   // TX word is captured whole on request acceptance, then walked out MSB first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx <= '0;
      end else if (i_load) begin
         r_tx <= i_loadWord;
      end else if (i_shiftTx) begin
         r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
      end
   end

   // RX byte assembles MSB first from MISO while the controller is capturing
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx <= '0;
      end else if (i_shiftRx) begin
         r_rx <= o_rxNext;
      end
   end

   // Phase counter: reloaded at each phase entry, counts down to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_cntLoad) begin
         r_cnt <= i_cntValue;
      end else if (i_cntDec) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_txMsb  = r_tx[FRAME_W-1];
   assign o_rxNext = {r_rx[RX_W-2:0], i_miso};
   assign o_cnt    = r_cnt;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator for the 10-bit command/address/data slave frame. Serialises
// one {cmd,din} word under SS_n and, for rd-data frames, captures the byte
// the slave returns on MISO. Every output is registered from the next state.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int RD_LAT    = 2,
   parameter int GAP_CYC   = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           cmd,
   input  logic [ADDR_SIZE-1:0] din,
   output logic                 ready,
   output logic                 done,
   output logic [ADDR_SIZE-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO
);

   localparam int FRAME_W = ADDR_SIZE + 2;
   localparam int CNT_MAX = maxOf(maxOf(FRAME_W - 1, RD_LAT - 1), GAP_CYC - 1);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   spiState_t r_state;
   spiState_t w_nextState;

   logic                 r_isRead;
   logic                 r_ssN;
   logic                 r_mosi;
   logic                 r_ready;
   logic                 r_done;
   logic                 r_rdValid;
   logic [ADDR_SIZE-1:0] r_rdData;

   logic                 w_load;
   logic                 w_shiftTx;
   logic                 w_shiftRx;
   logic                 w_cntLoad;
   logic [CNT_W-1:0]     w_cntValue;
   logic                 w_cntDec;
   logic                 w_captLast;
   logic                 w_doneNext;
   logic                 w_ssNNext;
   logic                 w_mosiNext;
   logic                 w_txMsb;
   logic [ADDR_SIZE-1:0] w_rxNext;
   logic [CNT_W-1:0]     w_cnt;
   logic                 w_cntZero;

   assign w_cntZero = (w_cnt == '0);

   spi_master_shifter #(
      .FRAME_W (FRAME_W),
      .RX_W    (ADDR_SIZE),
      .CNT_W   (CNT_W)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_loadWord ({cmd, din}),
      .i_shiftTx  (w_shiftTx),
      .i_shiftRx  (w_shiftRx),
      .i_miso     (MISO),
      .i_cntLoad  (w_cntLoad),
      .i_cntValue (w_cntValue),
      .i_cntDec   (w_cntDec),
      .o_txMsb    (w_txMsb),
      .o_rxNext   (w_rxNext),
      .o_cnt      (w_cnt)
   );

   // Next-state decode plus the pin values the next state will present
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_shiftRx   = 1'b0;
      w_cntLoad   = 1'b0;
      w_cntValue  = '0;
      w_cntDec    = 1'b0;
      w_captLast  = 1'b0;
      w_doneNext  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_nextState = ST_SEL;
            end
         end
         ST_SEL: begin
            w_nextState = ST_CMD;
         end
         ST_CMD: begin
            w_cntLoad   = 1'b1;
            w_cntValue  = CNT_W'(FRAME_W - 1);
            w_nextState = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (w_cntZero) begin
               w_cntLoad = 1'b1;
               if (r_isRead) begin
                  w_cntValue  = CNT_W'(RD_LAT - 1);
                  w_nextState = ST_WAIT;
               end else begin
                  w_cntValue  = CNT_W'(GAP_CYC - 1);
                  w_doneNext  = 1'b1;
                  w_nextState = ST_GAP;
               end
            end else begin
               w_cntDec = 1'b1;
            end
         end
         ST_WAIT: begin
            if (w_cntZero) begin
               w_cntLoad   = 1'b1;
               w_cntValue  = CNT_W'(ADDR_SIZE - 1);
               w_nextState = ST_CAPT;
            end else begin
               w_cntDec = 1'b1;
            end
         end
         ST_CAPT: begin
            w_shiftRx = 1'b1;
            if (w_cntZero) begin
               w_captLast  = 1'b1;
               w_doneNext  = 1'b1;
               w_cntLoad   = 1'b1;
               w_cntValue  = CNT_W'(GAP_CYC - 1);
               w_nextState = ST_GAP;
            end else begin
               w_cntDec = 1'b1;
            end
         end
         ST_GAP: begin
            if (w_cntZero) begin
               w_nextState = ST_IDLE;
            end else begin
               w_cntDec = 1'b1;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
      w_shiftTx  = (w_nextState == ST_SHIFT);
      w_ssNNext  = !(w_nextState inside {ST_SEL, ST_CMD, ST_SHIFT, ST_WAIT, ST_CAPT});
      w_mosiNext = (w_nextState == ST_CMD || w_nextState == ST_SHIFT) ? w_txMsb : 1'b0;
   end

   // State and registered pins; reset aborts any frame and clears the read byte
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_isRead  <= 1'b0;
         r_ssN     <= 1'b1;
         r_mosi    <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_rdValid <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_state   <= w_nextState;
         r_ssN     <= w_ssNNext;
         r_mosi    <= w_mosiNext;
         r_ready   <= (w_nextState == ST_IDLE);
         r_done    <= w_doneNext;
         r_rdValid <= w_captLast;
         if (w_load) begin
            r_isRead <= (cmd == CMD_RD_DATA);
         end
         if (w_captLast) begin
            r_rdData <= w_rxNext;
         end
      end
   end

   assign ready    = r_ready;
   assign done     = r_done;
   assign rd_data  = r_rdData;
   assign rd_valid = r_rdValid;
   assign SS_n     = r_ssN;
   assign MOSI     = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with a behavioural SPI slave + RAM.
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int AW     = 8;
   localparam int RD_LAT = 2;
   localparam int FB     = AW + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    cmd;
   logic [AW-1:0] din;
   logic          ready;
   logic          done;
   logic [AW-1:0] rd_data;
   logic          rd_valid;
   logic          SS_n;
   logic          MOSI;
   logic          MISO = 1'b0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [FB-1:0] bits;
      int            lowCycles;
      logic          isRead;
      logic [AW-1:0] rdData;
   } expFrame_t;

   expFrame_t expQ[$];

   always #5 clk = ~clk;

   spi_master_ctrl #(
      .ADDR_SIZE (AW),
      .RD_LAT    (RD_LAT),
      .GAP_CYC   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .cmd      (cmd),
      .din      (din),
      .ready    (ready),
      .done     (done),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Slave model: collects the frame, executes it against the RAM, returns read bytes
   logic [AW-1:0] ram [256];
   logic [AW-1:0] slvAddr   = '0;
   logic [AW-1:0] slvRdByte = '0;
   logic [FB-1:0] slvBits   = '0;
   logic          slvRead   = 1'b0;
   int            slvK      = 0;

   task automatic slaveDecode();
      logic [1:0]    c;
      logic [AW-1:0] p;
      c = slvBits[AW+1:AW];
      p = slvBits[AW-1:0];
      case (c)
         CMD_WR_ADDR: slvAddr = p;
         CMD_WR_DATA: ram[slvAddr] = p;
         CMD_RD_ADDR: slvAddr = p;
         default: begin
            slvRdByte = ram[slvAddr];
            slvRead   = 1'b1;
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (!SS_n) begin
         if (slvK < FB) slvBits = {slvBits[FB-2:0], MOSI};
         if (slvK == FB) slaveDecode();
         if (slvRead && slvK >= FB + RD_LAT && slvK < FB + RD_LAT + AW)
            MISO = slvRdByte[FB + RD_LAT + AW - 1 - slvK];
         else
            MISO = 1'($urandom);
         slvK++;
      end else begin
         if (slvK == FB) slaveDecode();
         slvK    = 0;
         slvRead = 1'b0;
         MISO    = 1'($urandom);
      end
   end

   // Monitor: records MOSI and SS_n window per frame, compares on every done
   logic [FB-1:0] monBits = '0;
   int            monLow  = 0;

   always @(negedge clk) begin
      expFrame_t e;
      if (!SS_n) begin
         if (monLow < FB) monBits = {monBits[FB-2:0], MOSI};
         monLow++;
      end
      if (done) begin
         checkOutput("done_has_pending_frame", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("frame_bits", 32'(monBits), 32'(e.bits));
            checkOutput("ss_low_cycles", 32'(monLow), 32'(e.lowCycles));
            checkOutput("rd_valid_with_done", 32'(rd_valid), 32'(e.isRead));
            checkOutput("rd_data", 32'(rd_data), 32'(e.rdData));
         end
      end else begin
         checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
      end
      if (SS_n) begin
         monLow  = 0;
         monBits = '0;
      end
   end

   task automatic waitReady();
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) checkOutput("ready_timeout", 32'(ready), 32'd1);
   endtask

   task automatic applyStimulus(input logic [1:0] c, input logic [AW-1:0] d,
                                input int lowCycles, input logic [AW-1:0] expRd);
      expFrame_t e;
      waitReady();
      e.bits      = {1'b0, c[1], c, d};
      e.lowCycles = lowCycles;
      e.isRead    = (c == CMD_RD_DATA);
      e.rdData    = expRd;
      expQ.push_back(e);
      start = 1'b1;
      cmd   = c;
      din   = d;
      @(negedge clk);
      start = 1'b0;
      cmd   = 2'($urandom);
      din   = AW'($urandom);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      rst   = 1'b1;
      start = 1'b0;
      cmd   = 2'b00;
      din   = '0;
      repeat (5) @(negedge clk);
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset_ss_n", 32'(SS_n), 32'd1);
      checkOutput("reset_mosi", 32'(MOSI), 32'd0);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);

      $display("[TB] write address, write data, read back");
      applyStimulus(CMD_WR_ADDR, 8'h05, 12, 8'h00);
      applyStimulus(CMD_WR_DATA, 8'h07, 12, 8'h00);
      applyStimulus(CMD_RD_ADDR, 8'h05, 12, 8'h00);
      applyStimulus(CMD_RD_DATA, 8'h00, 22, 8'h07);

      $display("[TB] preloaded RAM read");
      ram[3] = 8'hA5;
      applyStimulus(CMD_RD_ADDR, 8'h03, 12, 8'h07);
      applyStimulus(CMD_RD_DATA, 8'h5A, 22, 8'hA5);

      $display("[TB] start pulse during SHIFT is ignored");
      applyStimulus(CMD_WR_ADDR, 8'h3C, 12, 8'hA5);
      repeat (4) @(negedge clk);
      start = 1'b1;
      cmd   = CMD_RD_DATA;
      din   = 8'hFF;
      @(negedge clk);
      start = 1'b0;

      $display("[TB] reset during SHIFT aborts the frame");
      waitReady();
      start = 1'b1;
      cmd   = CMD_WR_DATA;
      din   = 8'h99;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_ss_n", 32'(SS_n), 32'd1);
      checkOutput("abort_mosi", 32'(MOSI), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_rd_data_cleared", 32'(rd_data), 32'd0);

      $display("[TB] frames after reset complete normally");
      applyStimulus(CMD_RD_ADDR, 8'h03, 12, 8'h00);
      applyStimulus(CMD_RD_DATA, 8'h00, 22, 8'hA5);

      begin
         int n = 0;
         while ((expQ.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("pending_frames", 32'(expQ.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
